// File: rtl/uart_rx_packet_parser.sv
// uart_rx_packet_parser
// Assembles SOF / LEN / payload / checksum frames from a UART receiver byte
// stream, verifies length, checksum, line errors and inter-byte timeout, and
// streams verified payloads out on a valid/ready port.
//
// Output handshake: pkt_valid/pkt_ready follow strict valid/ready semantics.
// A byte transfers on a rising edge where pkt_valid & pkt_ready are both high.
// Once pkt_valid is raised it stays high, and pkt_data, pkt_last and pkt_len
// hold their values, until that transfer happens. pkt_valid never depends
// combinationally on pkt_ready.
module uart_rx_packet_parser #(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_complete,
    input  logic [1:0] rx_error_bit,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic       pkt_last,
    output logic [7:0] pkt_len,
    output logic       pkt_ok,
    output logic [2:0] err_code,
    output logic [7:0] err_count,
    output logic [2:0] fsm_state
);

    // Buffer address width; a depth-1 buffer still needs one address bit.
    localparam int          AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int          DEPTH     = 1 << AW;
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_FRAME    = 3'd1;
    localparam logic [2:0] ERR_LENGTH   = 3'd2;
    localparam logic [2:0] ERR_CHECKSUM = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
    localparam logic [2:0] ERR_OVERRUN  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_SEND    = 3'd4
    } state_t;

    state_t      state;
    logic [7:0]  len_q;
    logic [7:0]  csum_q;
    logic [7:0]  idx_q;
    logic [7:0]  rd_q;
    logic [31:0] tmo_cnt;
    logic [7:0]  buf_mem [DEPTH];

    logic       byte_evt;
    logic       good_byte;
    logic       bad_byte;
    logic       tmo_hit;
    logic       buf_we;
    logic [7:0] rd_nxt;
    logic [7:0] len_m1;

    assign byte_evt  = rx_complete;
    assign good_byte = rx_complete && (rx_error_bit == 2'b00);
    assign bad_byte  = rx_complete && (rx_error_bit != 2'b00);
    assign tmo_hit   = (tmo_cnt == TMO_LAST);
    assign buf_we    = (state == ST_PAYLOAD) && good_byte;
    assign rd_nxt    = rd_q + 8'd1;
    assign len_m1    = len_q - 8'd1;
    assign fsm_state = state;

    // Payload buffer write; contents are only read after a full frame lands.
    always_ff @(posedge system_clk) begin
        if (buf_we) begin
            buf_mem[idx_q[AW-1:0]] <= rx_data;
        end
    end

    // Frame parser, verification and output streaming state machine.
    always_ff @(posedge system_clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            len_q     <= 8'd0;
            csum_q    <= 8'd0;
            idx_q     <= 8'd0;
            rd_q      <= 8'd0;
            tmo_cnt   <= 32'd0;
            pkt_data  <= 8'd0;
            pkt_valid <= 1'b0;
            pkt_last  <= 1'b0;
            pkt_len   <= 8'd0;
            pkt_ok    <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            pkt_ok   <= 1'b0;
            err_code <= ERR_NONE;
            case (state)
                ST_IDLE: begin
                    tmo_cnt <= 32'd0;
                    if (bad_byte) begin
                        err_code <= ERR_FRAME;
                    end else if (good_byte && (rx_data == SOF_BYTE)) begin
                        state <= ST_LEN;
                    end
                end

                ST_LEN: begin
                    if (byte_evt) begin
                        tmo_cnt <= 32'd0;
                        if (bad_byte) begin
                            err_code <= ERR_FRAME;
                            state    <= ST_IDLE;
                        end else begin
                            len_q  <= rx_data;
                            csum_q <= rx_data;
                            idx_q  <= 8'd0;
                            if (rx_data > MAX_LEN_B) begin
                                err_code <= ERR_LENGTH;
                                state    <= ST_IDLE;
                            end else if (rx_data == 8'd0) begin
                                state <= ST_CSUM;
                            end else begin
                                state <= ST_PAYLOAD;
                            end
                        end
                    end else if (tmo_hit) begin
                        err_code <= ERR_TIMEOUT;
                        state    <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end

                ST_PAYLOAD: begin
                    if (byte_evt) begin
                        tmo_cnt <= 32'd0;
                        if (bad_byte) begin
                            err_code <= ERR_FRAME;
                            state    <= ST_IDLE;
                        end else begin
                            csum_q <= csum_q ^ rx_data;
                            idx_q  <= idx_q + 8'd1;
                            if (idx_q == len_m1) begin
                                state <= ST_CSUM;
                            end
                        end
                    end else if (tmo_hit) begin
                        err_code <= ERR_TIMEOUT;
                        state    <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end

                ST_CSUM: begin
                    if (byte_evt) begin
                        tmo_cnt <= 32'd0;
                        if (bad_byte) begin
                            err_code <= ERR_FRAME;
                            state    <= ST_IDLE;
                        end else if (rx_data != csum_q) begin
                            err_code <= ERR_CHECKSUM;
                            state    <= ST_IDLE;
                        end else begin
                            pkt_ok <= 1'b1;
                            if (len_q == 8'd0) begin
                                state <= ST_IDLE;
                            end else begin
                                // Present the first byte in the cycle right after the checksum.
                                rd_q      <= 8'd0;
                                pkt_data  <= buf_mem[0];
                                pkt_valid <= 1'b1;
                                pkt_last  <= (len_q == 8'd1);
                                pkt_len   <= len_q;
                                state     <= ST_SEND;
                            end
                        end
                    end else if (tmo_hit) begin
                        err_code <= ERR_TIMEOUT;
                        state    <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end

                ST_SEND: begin
                    // No room for a new frame while streaming; the byte is dropped.
                    if (byte_evt) begin
                        err_code <= ERR_OVERRUN;
                    end
                    if (pkt_valid && pkt_ready) begin
                        if (pkt_last) begin
                            pkt_valid <= 1'b0;
                            pkt_last  <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            rd_q     <= rd_nxt;
                            pkt_data <= buf_mem[rd_nxt[AW-1:0]];
                            pkt_last <= (rd_nxt == len_m1);
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturating count of error pulses, trailing err_code by one cycle.
    always_ff @(posedge system_clk) begin
        if (reset) begin
            err_count <= 8'd0;
        end else if ((err_code != ERR_NONE) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_rx_packet_parser.sv
// Directed bench for uart_rx_packet_parser: good, checksum, length, zero
// length, line error, backpressure/overrun, timeout boundary and reset cases.
module tb_uart_rx_packet_parser;

  localparam int T = 64;

  logic       system_clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_complete;
  logic [1:0] rx_error_bit;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_ready;
  logic       pkt_last;
  logic [7:0] pkt_len;
  logic       pkt_ok;
  logic [2:0] err_code;
  logic [7:0] err_count;
  logic [2:0] fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  // {pkt_last, pkt_data} per transferred byte
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  uart_rx_packet_parser #(
    .MAX_LEN(16),
    .SOF_BYTE(8'hA5),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .system_clk(system_clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_complete(rx_complete),
    .rx_error_bit(rx_error_bit),
    .pkt_data(pkt_data),
    .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready),
    .pkt_last(pkt_last),
    .pkt_len(pkt_len),
    .pkt_ok(pkt_ok),
    .err_code(err_code),
    .err_count(err_count),
    .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 system_clk = ~system_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // output monitor: record every accepted byte
  always @(negedge system_clk) begin
    if (!reset && pkt_valid && pkt_ready) got_q.push_back({pkt_last, pkt_data});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [1:0] e);
    @(posedge system_clk); #1;
    rx_data = b; rx_error_bit = e; rx_complete = 1'b1;
    @(posedge system_clk); #1;
    rx_complete = 1'b0; rx_error_bit = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge system_clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(posedge system_clk); #1;
    reset = 1'b1;
    idle(n);
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard;
    int n;
    guard = 0;
    while (pkt_valid && guard < 200) begin
      idle(1);
      guard++;
    end
    check_eq({tag, "_drained"}, pkt_valid, 1'b0);
    check_eq({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_byte"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_complete = 1'b0; rx_error_bit = 2'b00; pkt_ready = 1'b1;
    idle(3);
    check_eq("rst_valid", pkt_valid, 1'b0);
    check_eq("rst_data", pkt_data, 8'h00);
    check_eq("rst_last", pkt_last, 1'b0);
    check_eq("rst_len", pkt_len, 8'h00);
    check_eq("rst_ok", pkt_ok, 1'b0);
    check_eq("rst_err", err_code, 3'd0);
    check_eq("rst_cnt", err_count, 8'd0);
    check_eq("rst_state", fsm_state, 3'd0);
    reset = 1'b0;

    // good packet, csum = 03^11^22^33 = 03
    send_byte(8'hA5, 2'b00); send_byte(8'h03, 2'b00);
    send_byte(8'h11, 2'b00); send_byte(8'h22, 2'b00); send_byte(8'h33, 2'b00);
    send_byte(8'h03, 2'b00);
    check_eq("good_ok", pkt_ok, 1'b1);
    check_eq("good_valid", pkt_valid, 1'b1);
    check_eq("good_d0", pkt_data, 8'h11);
    check_eq("good_len", pkt_len, 8'd3);
    check_eq("good_last0", pkt_last, 1'b0);
    idle(1);
    check_eq("good_ok_pulse", pkt_ok, 1'b0);
    check_eq("good_d1", pkt_data, 8'h22);
    idle(1);
    check_eq("good_d2", pkt_data, 8'h33);
    check_eq("good_last2", pkt_last, 1'b1);
    idle(1);
    check_eq("good_valid_fall", pkt_valid, 1'b0);
    exp_q.push_back({1'b0, 8'h11}); exp_q.push_back({1'b0, 8'h22}); exp_q.push_back({1'b1, 8'h33});
    drain("good");
    check_eq("good_errcnt", err_count, 8'd0);

    // checksum error, then a good packet (csum 02^AA^55 = FD)
    send_byte(8'hA5, 2'b00); send_byte(8'h03, 2'b00);
    send_byte(8'h11, 2'b00); send_byte(8'h22, 2'b00); send_byte(8'h33, 2'b00);
    send_byte(8'h04, 2'b00);
    check_eq("csum_err", err_code, 3'd3);
    check_eq("csum_novalid", pkt_valid, 1'b0);
    idle(1);
    check_eq("csum_err_pulse", err_code, 3'd0);
    check_eq("csum_errcnt", err_count, 8'd1);
    send_byte(8'hA5, 2'b00); send_byte(8'h02, 2'b00);
    send_byte(8'hAA, 2'b00); send_byte(8'h55, 2'b00); send_byte(8'hFD, 2'b00);
    check_eq("csum_next_ok", pkt_ok, 1'b1);
    exp_q.push_back({1'b0, 8'hAA}); exp_q.push_back({1'b1, 8'h55});
    drain("csum_next");

    // length error, then zero-length packet
    send_byte(8'hA5, 2'b00); send_byte(8'h11, 2'b00);
    check_eq("len_err", err_code, 3'd2);
    idle(1);
    check_eq("len_errcnt", err_count, 8'd2);
    send_byte(8'hA5, 2'b00); send_byte(8'h00, 2'b00); send_byte(8'h00, 2'b00);
    check_eq("zero_ok", pkt_ok, 1'b1);
    check_eq("zero_novalid", pkt_valid, 1'b0);
    idle(1);
    check_eq("zero_idle", fsm_state, 3'd0);
    check_eq("zero_novalid2", pkt_valid, 1'b0);

    // line error mid-payload, then single byte packet (csum 01^5A = 5B)
    send_byte(8'hA5, 2'b00); send_byte(8'h02, 2'b00); send_byte(8'h5A, 2'b01);
    check_eq("line_err", err_code, 3'd1);
    check_eq("line_idle", fsm_state, 3'd0);
    idle(1);
    check_eq("line_errcnt", err_count, 8'd3);
    send_byte(8'hA5, 2'b00); send_byte(8'h01, 2'b00);
    send_byte(8'h5A, 2'b00); send_byte(8'h5B, 2'b00);
    check_eq("one_data", pkt_data, 8'h5A);
    check_eq("one_last", pkt_last, 1'b1);
    check_eq("one_valid", pkt_valid, 1'b1);
    exp_q.push_back({1'b1, 8'h5A});
    drain("one");

    // backpressure + overrun (csum 03^C1^C2^C3 = C3)
    pkt_ready = 1'b0;
    send_byte(8'hA5, 2'b00); send_byte(8'h03, 2'b00);
    send_byte(8'hC1, 2'b00); send_byte(8'hC2, 2'b00); send_byte(8'hC3, 2'b00);
    send_byte(8'hC3, 2'b00);
    check_eq("bp_valid", pkt_valid, 1'b1);
    check_eq("bp_d0", pkt_data, 8'hC1);
    idle(3);
    send_byte(8'h77, 2'b00);
    check_eq("ovr_err", err_code, 3'd5);
    idle(5);
    check_eq("bp_hold_valid", pkt_valid, 1'b1);
    check_eq("bp_hold_data", pkt_data, 8'hC1);
    check_eq("bp_hold_last", pkt_last, 1'b0);
    check_eq("bp_hold_len", pkt_len, 8'd3);
    check_eq("ovr_errcnt", err_count, 8'd4);
    pkt_ready = 1'b1;
    exp_q.push_back({1'b0, 8'hC1}); exp_q.push_back({1'b0, 8'hC2}); exp_q.push_back({1'b1, 8'hC3});
    drain("bp");

    // timeout: exact terminal cycle
    send_byte(8'hA5, 2'b00); send_byte(8'h03, 2'b00); send_byte(8'h11, 2'b00);
    repeat (T - 1) @(posedge system_clk);
    #1;
    check_eq("tmo_early", err_code, 3'd0);
    check_eq("tmo_early_state", fsm_state, 3'd2);
    idle(1);
    check_eq("tmo_err", err_code, 3'd4);
    check_eq("tmo_idle", fsm_state, 3'd0);
    idle(1);
    check_eq("tmo_errcnt", err_count, 8'd5);

    // byte on the timeout cycle wins
    send_byte(8'hA5, 2'b00); send_byte(8'h03, 2'b00);
    repeat (T - 2) @(posedge system_clk);
    send_byte(8'h44, 2'b00);
    check_eq("tmo_race_err", err_code, 3'd0);
    check_eq("tmo_race_state", fsm_state, 3'd2);

    // reset mid-frame
    do_reset(2);
    check_eq("rstf_state", fsm_state, 3'd0);
    check_eq("rstf_err", err_code, 3'd0);
    check_eq("rstf_cnt", err_count, 8'd0);
    idle(1);
    check_eq("rstf_err2", err_code, 3'd0);

    // reset mid-SEND (csum 01^99 = 98)
    pkt_ready = 1'b0;
    send_byte(8'hA5, 2'b00); send_byte(8'h01, 2'b00);
    send_byte(8'h99, 2'b00); send_byte(8'h98, 2'b00);
    check_eq("rsts_valid_pre", pkt_valid, 1'b1);
    do_reset(2);
    check_eq("rsts_valid", pkt_valid, 1'b0);
    check_eq("rsts_len", pkt_len, 8'd0);
    check_eq("rsts_state", fsm_state, 3'd0);

    // clean packet after reset (csum 01^42 = 43)
    pkt_ready = 1'b1;
    send_byte(8'hA5, 2'b00); send_byte(8'h01, 2'b00);
    send_byte(8'h42, 2'b00); send_byte(8'h43, 2'b00);
    check_eq("post_data", pkt_data, 8'h42);
    exp_q.push_back({1'b1, 8'h42});
    drain("post");
    check_eq("post_errcnt", err_count, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_packet_parser.md
# uart_rx_packet_parser

Downstream consumer of the UART receiver in `customUartTop`. It takes the byte stream (`dout` / `rx_complete` / `rx_error_bit`) and assembles framed packets of the form SOF, LEN, payload, checksum. Each packet is checked for length, checksum, line errors and inter-byte timeout. Only verified payloads are buffered and then streamed out on a valid/ready interface.

## Interface
Parameters:
- `MAX_LEN`, 16: maximum payload bytes (buffer depth); range 1..255.
- `SOF_BYTE`, 8'hA5: start-of-frame marker.
- `TIMEOUT_CYCLES`, 100000: maximum system_clk cycles allowed between bytes inside a frame.

Ports:
- `system_clk` in 1: sole clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: received byte; sampled only when `rx_complete`=1.
- `rx_complete` in 1: one-cycle strobe, byte available.
- `rx_error_bit` in 2: nonzero together with `rx_complete` marks a bad byte (stop-bit/line error).
- `pkt_data` out 8: payload byte.
- `pkt_valid` out 1: `pkt_data` valid.
- `pkt_ready` in 1: consumer accepts when `pkt_valid` & `pkt_ready`.
- `pkt_last` out 1: final payload byte of the packet.
- `pkt_len` out 8: LEN of the packet being streamed; held during SEND.
- `pkt_ok` out 1: one-cycle pulse, packet verified.
- `err_code` out 3: one-cycle pulse code (0 none, 1 frame, 2 length, 3 checksum, 4 timeout, 5 overrun).
- `err_count` out 8: saturating count of nonzero `err_code` events.

## Operation
- Byte event = `rx_complete`=1. Good byte = `rx_error_bit`==0.

States and transitions:
- IDLE: on a good byte equal to `SOF_BYTE`, go to LEN. Other good bytes are ignored. A bad byte gives `err_code`=1 and stays in IDLE.
- LEN: on a good byte, latch it as len and set csum = byte.
  - len > `MAX_LEN`: `err_code`=2, go to IDLE.
  - len == 0: go to CSUM.
  - otherwise: go to PAYLOAD with idx = 0.
- PAYLOAD: each good byte is written to buf[idx] and XORed into csum, then idx increments. After byte len-1 is written, go to CSUM.
- CSUM: on a good byte:
  - byte == csum and len > 0: pulse `pkt_ok`, go to SEND.
  - byte == csum and len == 0: pulse `pkt_ok`, go to IDLE.
  - mismatch: `err_code`=3, go to IDLE.
- SEND: present buf[rd] with `pkt_valid`=1 and `pkt_last` = (rd == len-1). On handshake, rd increments. The handshake on the last byte returns to IDLE.
  - Any byte event during SEND is discarded with `err_code`=5.

Errors and timeout:
- A bad byte in LEN, PAYLOAD or CSUM gives `err_code`=1 and returns to IDLE.
- Timeout counter runs in LEN, PAYLOAD and CSUM. It clears on entry to each of these states and on every byte event.
- When the counter reaches `TIMEOUT_CYCLES`-1, the block gives `err_code`=4 and returns to IDLE.
- A byte event in the same cycle as the timeout wins: the byte is processed and no timeout is reported.

Other rules:
- Checksum is the 8-bit XOR of LEN and all payload bytes.
- `err_count` increments on every nonzero `err_code` and saturates at 255.
- Reset mid-frame or mid-SEND: immediate return to IDLE. Partial data is discarded and no error pulse is generated.

## Timing
- Reset values:
  - `pkt_data`=0, `pkt_valid`=0, `pkt_last`=0, `pkt_len`=0.
  - `pkt_ok`=0, `err_code`=0, `err_count`=0.
  - State IDLE; internal counters 0.
- Checksum byte strobe in cycle N:
  - `pkt_ok` is high in N+1.
  - SEND is entered in N+1, so `pkt_valid`=1 with buf[0] on `pkt_data` in N+1.
- Streaming: `pkt_data`, `pkt_valid` and `pkt_last` are registered. When `pkt_ready` is held high, one byte transfers per cycle.
- `pkt_data`, `pkt_last` and `pkt_len` are stable while `pkt_valid`=1 and `pkt_ready`=0.
- `pkt_valid` falls in the cycle after the last handshake.
- The parser accepts the next SOF in the cycle after SEND exits. IDLE-to-LEN needs no gap.
- Error pulses appear one cycle after the offending strobe, or one cycle after the timeout terminal count.

## Test plan
- Good packet: A5 03 11 22 33 03 with `pkt_ready`=1 -> `pkt_ok` pulse, then 11, 22, 33 on consecutive cycles, `pkt_last` on 33, `pkt_len`=3, `err_count`=0.
- Checksum error: A5 03 11 22 33 04 -> `err_code`=3, `pkt_valid` never asserted, `err_count`=1; a following good packet is received normally.
- Length error and zero length: A5 11 (MAX_LEN=16) -> `err_code`=2. Then A5 00 00 -> `pkt_ok` pulse with no `pkt_valid`.
- Line error: A5 02 5A with `rx_error_bit`=2'b01 on the 5A -> `err_code`=1, back to IDLE. Then A5 01 5A 5B -> `pkt_data`=5A with `pkt_last`.
- Backpressure and overrun: good 3-byte packet, `pkt_ready` low for 10 cycles, a byte arrives during SEND -> data held stable, `err_code`=5, all 3 bytes still delivered in order.
- Timeout and reset: A5 03 11, then idle for `TIMEOUT_CYCLES` -> `err_code`=4. A second partial frame interrupted by `reset` -> no outputs, `err_count` cleared to 0.
